multicycle_control: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath: unified instruction/data memory, IR, register file, ALU, ALUOut/MDR/oldPC registers and PC.
- Moore-style: every output decodes from the current state. The one exception is the branch PC write, which also depends on zero_i and funct3_i.
- Instantiated inside core_top, alongside the datapath and memory.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/next_state_decoder.sv | 25 ++
 rtl/multicycle_control.sv | 145 ++++++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I core: controller states, opcodes
// and datapath mux/ALU select codes.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_JALR     = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/next_state_decoder.sv
// Maps the IR opcode to the state that follows DECODE.
module next_state_decoder
  import core_pkg::*;
(
  input  logic [6:0] opcode_i,
  output state_t     decode_next_o
);

  always_comb begin
    decode_next_o = S_ILLEGAL;
    case (opcode_i)
      OP_LOAD,
      OP_STORE:  decode_next_o = S_MEMADR;
      OP_RTYPE:  decode_next_o = S_EXECR;
      OP_ITYPE:  decode_next_o = S_EXECI;
      OP_BRANCH: decode_next_o = S_BRANCH;
      OP_JAL:    decode_next_o = S_JAL;
      OP_JALR:   decode_next_o = S_JALR;
      OP_LUI:    decode_next_o = S_LUI;
      OP_AUIPC:  decode_next_o = S_AUIPC;
      default:   decode_next_o = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core. Outputs are decoded from the
// current state; only the branch PC write also looks at zero_i/funct3_i.
module multicycle_control
  import core_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       adr_src_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [3:0] state_o
);

  state_t state, state_next, decode_next;
  logic   pc_write, ir_write, mem_read, mem_write, reg_write;
  logic   unused_funct3;

  // BEQ/BNE differ only in funct3[0]; the other bits carry no meaning here.
  assign unused_funct3 = ^funct3_i[2:1];

  next_state_decoder u_next_state_decoder (
    .opcode_i      (opcode_i),
    .decode_next_o (decode_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE:   state_next = decode_next;
      S_MEMADR:   state_next = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_EXECI:    state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_BRANCH:   state_next = S_FETCH;
      S_LUI:      state_next = S_ALUWB;
      S_AUIPC:    state_next = S_ALUWB;
      // JALR computes its target, then shares the link/PC-load step of JAL.
      S_JALR:     state_next = S_JAL;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    adr_src_o    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALU_ADD;
    result_src_o = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        mem_read     = 1'b1;
        ir_write     = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        pc_write     = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMADR, S_JALR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        mem_read  = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = RES_MDR;
        reg_write    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALU_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_EXECI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_FUNCT;
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALU_SUB;
        pc_write    = zero_i ^ funct3_i[0];
      end
      S_LUI: begin
        alu_src_a_o = SRCA_ZERO;
        alu_src_b_o = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
      end
      default: ;
    endcase
  end

  // Reset gates every enable combinationally so nothing is written after rst_n falls.
  assign pc_write_o  = pc_write  & rst_n;
  assign ir_write_o  = ir_write  & rst_n;
  assign mem_read_o  = mem_read  & rst_n;
  assign mem_write_o = mem_write & rst_n;
  assign reg_write_o = reg_write & rst_n;
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected output
// sequences are queued and compared on every falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_i = 7'b0110011;
  logic [2:0] funct3_i = 3'b000;
  logic       zero_i = 1'b0;
  logic       pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  logic [17:0] dut_vec;

  multicycle_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .zero_i       (zero_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .adr_src_o    (adr_src_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .state_o      (state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  assign dut_vec = {pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o,
                    alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, state_o};

  // Model: what the bundle of outputs must be while the controller sits in step st.
  // Layout {pw, iw, as, mr, mw, rw, a[2], b[2], op[2], rs[2], state[4]}.
  function automatic logic [17:0] exp_out(input int st, input bit z, input bit f0);
    logic pw, iw, as, mr, mw, rw;
    logic [1:0] a, b, op, rs;
    logic [3:0] s4;
    {pw, iw, as, mr, mw, rw} = 6'b0;
    a = 2'd0; b = 2'd0; op = 2'd0; rs = 2'd0;
    s4 = 4'(st);
    case (st)
      0:  begin mr = 1; iw = 1; b = 2'd2; rs = 2'd2; pw = 1; end
      1:  begin a = 2'd1; b = 2'd1; end
      2:  begin a = 2'd2; b = 2'd1; end
      3:  begin as = 1; mr = 1; end
      4:  begin rs = 2'd1; rw = 1; end
      5:  begin as = 1; mw = 1; end
      6:  begin a = 2'd2; op = 2'd2; end
      7:  rw = 1;
      8:  begin a = 2'd2; b = 2'd1; op = 2'd2; end
      9:  begin a = 2'd1; b = 2'd2; pw = 1; end
      10: begin a = 2'd2; op = 2'd1; pw = z ^ f0; end
      11: begin a = 2'd3; b = 2'd1; end
      12: begin a = 2'd1; b = 2'd1; end
      13: begin a = 2'd2; b = 2'd1; end
      default: ;
    endcase
    return {pw, iw, as, mr, mw, rw, a, b, op, rs, s4};
  endfunction

  // In reset the FETCH selects remain but every enable is held low.
  localparam logic [17:0] RESET_VEC = {6'b000000, 2'd0, 2'd2, 2'd0, 2'd2, 4'd0};

  // Model: sequence of steps an instruction walks through, FETCH first.
  task automatic push_instr(input logic [6:0] op, input bit z, input bit f0);
    int s[$];
    s.push_back(0);
    s.push_back(1);
    case (op)
      7'b0000011: begin s.push_back(2); s.push_back(3); s.push_back(4); end
      7'b0100011: begin s.push_back(2); s.push_back(5); end
      7'b0110011: begin s.push_back(6); s.push_back(7); end
      7'b0010011: begin s.push_back(8); s.push_back(7); end
      7'b1100011: s.push_back(10);
      7'b1101111: begin s.push_back(9); s.push_back(7); end
      7'b1100111: begin s.push_back(13); s.push_back(9); s.push_back(7); end
      7'b0110111: begin s.push_back(11); s.push_back(7); end
      7'b0010111: begin s.push_back(12); s.push_back(7); end
      default: for (int i = 0; i < 20; i++) s.push_back(14);
    endcase
    foreach (s[i]) exp_q.push_back(exp_out(s[i], z, f0));
  endtask

  // Scoreboard compare process
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL seq_check t=%0t state=%0d got=%b exp=%b", $time, state_o, dut_vec, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Driver: called #1 after the edge that entered FETCH; returns likewise.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input int cycles);
    int n;
    opcode_i = op;
    funct3_i = f3;
    zero_i   = z;
    push_instr(op, z, f3[0]);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_o != 4'd0 && n < 40);
    check({name, "_cycles"}, n, cycles);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset held for three edges with an R-type opcode present.
    exp_q.push_back(RESET_VEC);
    exp_q.push_back(RESET_VEC);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", state_o, 0);
    check("reset_pc_write", pc_write_o, 0);
    rst_n = 1'b1;
    #1;
    check("release_pc_write", pc_write_o, 1);
    check("release_ir_write", ir_write_o, 1);
    #(-1+1);

    run_instr("rtype",  7'b0110011, 3'b000, 1'b0, 4);
    run_instr("load",   7'b0000011, 3'b010, 1'b0, 5);
    run_instr("store",  7'b0100011, 3'b010, 1'b0, 4);
    run_instr("beq_t",  7'b1100011, 3'b000, 1'b1, 3);
    run_instr("beq_nt", 7'b1100011, 3'b000, 1'b0, 3);
    run_instr("bne_t",  7'b1100011, 3'b001, 1'b0, 3);
    run_instr("bne_nt", 7'b1100011, 3'b001, 1'b1, 3);
    run_instr("jalr",   7'b1100111, 3'b000, 1'b0, 5);
    run_instr("jal",    7'b1101111, 3'b000, 1'b0, 4);
    run_instr("itype",  7'b0010011, 3'b000, 1'b0, 4);
    run_instr("lui",    7'b0110111, 3'b000, 1'b0, 4);
    run_instr("auipc",  7'b0010111, 3'b000, 1'b0, 4);

    // Illegal opcode: parks in step 14 until reset.
    opcode_i = 7'b1111111;
    push_instr(opcode_i, 1'b0, 1'b0);
    repeat (22) @(posedge clk);
    @(negedge clk);
    #1;
    check("illegal_hold_state", state_o, 14);
    check("illegal_queue_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("illegal_reset_state", state_o, 0);
    check("illegal_reset_enables",
          {pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("after_illegal", 7'b0110011, 3'b000, 1'b0, 4);

    // Reset in the middle of MEMWRITE must drop mem_write immediately.
    opcode_i = 7'b0100011;
    exp_q.push_back(exp_out(0, 1'b0, 1'b0));
    exp_q.push_back(exp_out(1, 1'b0, 1'b0));
    exp_q.push_back(exp_out(2, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    check("memwrite_state", state_o, 5);
    check("memwrite_strobe", mem_write_o, 1);
    rst_n = 1'b0;
    #1;
    check("memwrite_abort_strobe", mem_write_o, 0);
    check("memwrite_abort_state", state_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("after_abort", 7'b0000011, 3'b000, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
